// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - byte stream input and instruction-memory write port of im_loader
interface im_loader_if #(
  parameter int ADDR_WIDTH = 7
) ();
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;

  // loader side
  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

  // stream source / instruction-memory side
  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - instruction-memory loader: byte stream to 32-bit words, holds CPU in reset while loading
module im_loader #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] load_len,
  input  logic                abort,
  im_loader_if.master         bus,
  output logic                busy,
  output logic                done,
  output logic                cpu_rstn
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest legal length: the whole memory, so the address never wraps.
  localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            cnt_q;
  logic [31:0]           word_q;
  logic                  in_ready_c;
  logic                  im_we_c;
  logic                  done_c;
  logic                  last_word;
  logic                  load_go;
  logic [ADDR_WIDTH:0]   len_clamped;

  assign last_word   = (({1'b0, idx_q} + LEN_ONE) == len_q);
  assign load_go     = start && (load_len != '0);
  assign len_clamped = (load_len > CAPACITY) ? CAPACITY : load_len;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-decoded strobes; abort wins over any byte or write progress
  always_comb begin
    next_state = state;
    in_ready_c = 1'b0;
    im_we_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (load_len != '0) ? RECV : DONE;
        end
      end
      RECV: begin
        in_ready_c = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (bus.in_valid && (cnt_q == 2'd3)) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        im_we_c = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (last_word) begin
          next_state = DONE;
        end else begin
          next_state = RECV;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: length latch, word assembly, word index, busy and CPU reset control
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= 2'd0;
      word_q   <= 32'd0;
      busy     <= 1'b0;
      cpu_rstn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_go) begin
            len_q    <= len_clamped;
            idx_q    <= '0;
            cnt_q    <= 2'd0;
            busy     <= 1'b1;
            cpu_rstn <= 1'b0;
          end
        end
        RECV: begin
          if (abort) begin
            cnt_q <= 2'd0;
            busy  <= 1'b0;
          end else if (bus.in_valid) begin
            word_q <= {word_q[23:0], bus.in_data};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        WRITE: begin
          if (abort) begin
            cnt_q <= 2'd0;
            busy  <= 1'b0;
          end else if (!last_word) begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE: begin
          busy     <= 1'b0;
          cpu_rstn <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.im_we    = im_we_c;
  assign bus.im_addr  = idx_q;
  assign bus.im_wdata = word_q;
  assign done         = done_c;

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - scoreboard testbench for im_loader
module tb_im_loader;
  localparam int AW = 7;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW:0]   load_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          cpu_rstn;

  im_loader_if #(.ADDR_WIDTH(AW)) bus ();

  im_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .load_len (load_len),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .cpu_rstn (cpu_rstn)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int writes_seen = 0;
  logic [AW+31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write strobe pops and compares one expected write
  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      if (bus.im_we === 1'b1) begin
        writes_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: got addr=%0d data=0x%08h, required no write",
                   bus.im_addr, bus.im_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.im_addr, bus.im_wdata} !== e) begin
            errors++;
            $display("FAIL sb_write: got addr=%0d data=0x%08h, required addr=%0d data=0x%08h",
                     bus.im_addr, bus.im_wdata, e[AW+31:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b ^ 8'hA5, 8'h3C, ~b};
  endfunction

  task automatic expect_write(input int addr, input logic [31:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  task automatic do_start(input logic [AW:0] len);
    start = 1'b1;
    load_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      t++;
      if (t > 50) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc - s_cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
    check({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
    check({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
  endtask

  initial begin
    int at;
    int w0;
    int nd;
    logic [7:0] bytes2 [8];
    int gaps [8];
    logic [7:0] abytes [6];

    bytes2 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    gaps   = '{0, 2, 1, 3, 0, 1, 2, 0};
    abytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rstn = 1'b0;
    start = 1'b0;
    load_len = '0;
    abort = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;

    // Reset values, and in_ready stays low in IDLE even with data offered
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    // Zero-length load
    w0 = writes_seen;
    do_start(0);
    wait_done(at);
    check("len0_done_cycle", 32'(at), 32'd0);
    @(negedge clk);
    check("len0_cpu_rstn", 32'(cpu_rstn), 32'd1);
    check("len0_writes", 32'(writes_seen - w0), 32'd0);
    @(posedge clk); #1;

    // Two words, no gaps
    w0 = writes_seen;
    expect_write(0, 32'h20080005);
    expect_write(1, 32'h0000000C);
    do_start(2);
    check("len2_busy", 32'(busy), 32'd1);
    check("len2_cpu_rstn_low", 32'(cpu_rstn), 32'd0);
    check("len2_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(bytes2[i], 0);
    bus.in_valid = 1'b0;
    wait_done(at);
    check("len2_done_cycle", 32'(at), 32'd10);
    check("len2_cpu_rstn_at_done", 32'(cpu_rstn), 32'd0);
    @(negedge clk);
    check("len2_cpu_rstn_rise", 32'(cpu_rstn), 32'd1);
    check("len2_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("len2_writes", 32'(writes_seen - w0), 32'd2);
    check("len2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Same load with gaps; a start while busy must not restart
    w0 = writes_seen;
    expect_write(0, 32'h20080005);
    expect_write(1, 32'h0000000C);
    do_start(2);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes2[i], gaps[i]);
      if (i == 2) begin
        bus.in_valid = 1'b0;
        start = 1'b1;
        load_len = 1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    wait_done(at);
    check("gap_done_seen", 32'(at >= 0), 32'd1);
    @(negedge clk);
    check("gap_cpu_rstn", 32'(cpu_rstn), 32'd1);
    @(posedge clk); #1;
    check("gap_writes", 32'(writes_seen - w0), 32'd2);
    check("gap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort after six bytes, with a byte offered in the abort cycle
    w0 = writes_seen;
    expect_write(0, 32'h11223344);
    do_start(2);
    check("abort_cpu_rstn_low", 32'(cpu_rstn), 32'd0);
    for (int i = 0; i < 6; i++) send_byte(abytes[i], 0);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    @(posedge clk); #1;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    @(posedge clk); #1;
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_cpu_rstn", 32'(cpu_rstn), 32'd0);
    check("abort_writes", 32'(writes_seen - w0), 32'd1);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    // Single word after the abort
    w0 = writes_seen;
    expect_write(0, 32'hDEADBEEF);
    do_start(1);
    send_word(32'hDEADBEEF, 0);
    bus.in_valid = 1'b0;
    wait_done(at);
    check("len1_done_cycle", 32'(at), 32'd5);
    @(negedge clk);
    check("len1_cpu_rstn", 32'(cpu_rstn), 32'd1);
    @(posedge clk); #1;
    check("len1_writes", 32'(writes_seen - w0), 32'd1);

    // Full memory, requested length above capacity is clamped
    w0 = writes_seen;
    for (int i = 0; i < 128; i++) expect_write(i, pat(i));
    do_start(200);
    for (int i = 0; i < 128; i++) send_word(pat(i), 0);
    bus.in_valid = 1'b0;
    wait_done(at);
    check("full_done_cycle", 32'(at), 32'd640);
    @(posedge clk); #1;
    check("full_writes", 32'(writes_seen - w0), 32'd128);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-load
    w0 = writes_seen;
    for (int i = 0; i < 10; i++) expect_write(i, pat(i));
    do_start(128);
    for (int i = 0; i < 10; i++) send_word(pat(i), 0);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bus.in_valid = 1'b1;
    bus.in_data = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("midrst_writes", 32'(writes_seen - w0), 32'd10);
    check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
